hazard_ctrl: RTL and testbench

- Pipeline controller for the 5-stage MIPS datapath.
- Sequences the IF/ID, ID/EX and EX/MEM pipeline registers by generating stall, flush and forwarding selects.
- Detects load-use hazards against EX and MEM.
- Resolves taken branches and jumps in MEM by flushing the younger stages.
- Owns a multi-cycle mult/div busy sequencer and a stall-cycle performance counter.
- Sits beside the datapath: reads stage register fields and drives the enable/flush inputs of the stage registers.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_ctrl_md_seq.sv | 52 +++++
 rtl/hazard_ctrl.sv | 90 +++++++++
 tb/tb_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller:
// forwarding selects, mult/div sequencer states and the register-match helper.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } md_state_e;

    // $zero is hardwired, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Stage-register fields read from the datapath and the stall/flush/forward
// controls driven back into it.
interface hazard_ctrl_if;

    logic [4:0] rs_D, rt_D;
    logic       use_rs_D, use_rt_D, md_use_D;
    logic [4:0] rs_E, rt_E, dst_E;
    logic       RegWr_E, MemtoReg_E, md_start_E;
    logic [4:0] dst_M;
    logic       RegWr_M, MemtoReg_M, br_taken_M;
    logic [4:0] dst_W;
    logic       RegWr_W;

    logic        stall_F, stall_D;
    logic        flush_D, flush_E, flush_M;
    logic [1:0]  fwdA_E, fwdB_E;
    logic        md_busy, md_go;
    logic [31:0] stall_cnt;

    modport master (
        output rs_D, rt_D, use_rs_D, use_rt_D, md_use_D,
        output rs_E, rt_E, dst_E, RegWr_E, MemtoReg_E, md_start_E,
        output dst_M, RegWr_M, MemtoReg_M, br_taken_M,
        output dst_W, RegWr_W,
        input  stall_F, stall_D, flush_D, flush_E, flush_M,
        input  fwdA_E, fwdB_E, md_busy, md_go, stall_cnt
    );

    modport slave (
        input  rs_D, rt_D, use_rs_D, use_rt_D, md_use_D,
        input  rs_E, rt_E, dst_E, RegWr_E, MemtoReg_E, md_start_E,
        input  dst_M, RegWr_M, MemtoReg_M, br_taken_M,
        input  dst_W, RegWr_W,
        output stall_F, stall_D, flush_D, flush_E, flush_M,
        output fwdA_E, fwdB_E, md_busy, md_go, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// Mult/div busy sequencer: after an accepted start it stays busy for exactly
// MD_LATENCY cycles, counting md_cnt down to zero.
module md_seq
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_go,
    output logic md_busy
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // NOTE: defaults first, so no path through the case leaves a variable
    // unassigned and a latch can never be inferred.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (md_go) begin
                    md_cnt_d = CNT_W'(MD_LATENCY - 1);
                    state_d  = ST_MD_BUSY;
                end
            end
            ST_MD_BUSY: begin
                if (md_cnt_q == '0) state_d = ST_RUN;
                else                md_cnt_d = md_cnt_q - CNT_W'(1);
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign md_busy = (state_q == ST_MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS pipeline controller: operand forwarding, load-use and mult/div
// stalls, MEM-stage branch flushes and a stall-cycle performance counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hif
);

    logic        md_go_raw, md_busy_q;
    logic        lu, md_hz, hz;
    logic        stall_f, stall_d, flush_d, flush_e, flush_m;
    logic [31:0] stall_cnt_q;

    assign md_go_raw = hif.md_start_E && !hif.br_taken_M;

    md_seq #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_md_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .md_go   (md_go_raw),
        .md_busy (md_busy_q)
    );

    // A load still in EX or MEM cannot supply its value to ID in time.
    always_comb begin
        lu = 1'b0;
        if (hif.use_rs_D && hif.RegWr_E && hif.MemtoReg_E && reg_match(hif.dst_E, hif.rs_D)) lu = 1'b1;
        if (hif.use_rt_D && hif.RegWr_E && hif.MemtoReg_E && reg_match(hif.dst_E, hif.rt_D)) lu = 1'b1;
        if (hif.use_rs_D && hif.RegWr_M && hif.MemtoReg_M && reg_match(hif.dst_M, hif.rs_D)) lu = 1'b1;
        if (hif.use_rt_D && hif.RegWr_M && hif.MemtoReg_M && reg_match(hif.dst_M, hif.rt_D)) lu = 1'b1;
    end

    assign md_hz = hif.md_use_D && (md_busy_q || md_go_raw);
    assign hz    = lu || md_hz;

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (!rst_n) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else if (hif.br_taken_M) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else if (hz) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Loads in MEM are excluded: their data only exists from WB onward.
    always_comb begin
        hif.fwdA_E = FWD_RF;
        hif.fwdB_E = FWD_RF;
        if (rst_n) begin
            if (hif.RegWr_M && !hif.MemtoReg_M && reg_match(hif.dst_M, hif.rs_E)) hif.fwdA_E = FWD_MEM;
            else if (hif.RegWr_W && reg_match(hif.dst_W, hif.rs_E))               hif.fwdA_E = FWD_WB;
            if (hif.RegWr_M && !hif.MemtoReg_M && reg_match(hif.dst_M, hif.rt_E)) hif.fwdB_E = FWD_MEM;
            else if (hif.RegWr_W && reg_match(hif.dst_W, hif.rt_E))               hif.fwdB_E = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       stall_cnt_q <= '0;
        else if (stall_f) stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign hif.stall_F   = stall_f;
    assign hif.stall_D   = stall_d;
    assign hif.flush_D   = flush_d;
    assign hif.flush_E   = flush_e;
    assign hif.flush_M   = flush_m;
    assign hif.md_go     = md_go_raw && rst_n;
    assign hif.md_busy   = md_busy_q && rst_n;
    assign hif.stall_cnt = rst_n ? stall_cnt_q : 32'd0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// pipeline traffic, compared against a cycle-level reference model.
module tb_hazard_ctrl;

    localparam int LAT = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if hif ();

    hazard_ctrl #(
        .MD_LATENCY (LAT),
        .CNT_W      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: remaining busy cycles and stall count.
    int          m_rem = 0;
    logic [31:0] m_cnt = 32'd0;

    logic        e_stall_F, e_stall_D, e_flush_D, e_flush_E, e_flush_M;
    logic [1:0]  e_fwdA, e_fwdB;
    logic        e_busy, e_go;
    logic [31:0] e_cnt;
    logic [31:0] base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (hif.RegWr_M && !hif.MemtoReg_M && hif.dst_M != 0 && hif.dst_M == src) return 2'd2;
        if (hif.RegWr_W && hif.dst_W != 0 && hif.dst_W == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic m_dep(input logic [4:0] r, input logic use_r);
        if (!use_r || r == 0) return 1'b0;
        return (hif.RegWr_E && hif.MemtoReg_E && hif.dst_E == r) ||
               (hif.RegWr_M && hif.MemtoReg_M && hif.dst_M == r);
    endfunction

    task automatic compute_expected();
        logic go, hazard;
        go     = hif.md_start_E && !hif.br_taken_M;
        hazard = m_dep(hif.rs_D, hif.use_rs_D) || m_dep(hif.rt_D, hif.use_rt_D) ||
                 (hif.md_use_D && (m_rem > 0 || go));
        {e_stall_F, e_stall_D, e_flush_D, e_flush_E, e_flush_M} = 5'b0;
        e_fwdA = 2'd0;
        e_fwdB = 2'd0;
        e_busy = 1'b0;
        e_go   = 1'b0;
        e_cnt  = 32'd0;
        if (!rst_n) begin
            {e_flush_D, e_flush_E, e_flush_M} = 3'b111;
        end else begin
            e_fwdA = m_fwd(hif.rs_E);
            e_fwdB = m_fwd(hif.rt_E);
            e_busy = (m_rem > 0);
            e_go   = go;
            e_cnt  = m_cnt;
            if (hif.br_taken_M) begin
                {e_flush_D, e_flush_E, e_flush_M} = 3'b111;
            end else if (hazard) begin
                {e_stall_F, e_stall_D, e_flush_E} = 3'b111;
            end
        end
    endtask

    // Wait to the falling edge and compare every output against the model.
    task automatic settle(input string tag);
        @(negedge clk);
        compute_expected();
        check({tag, ".stall_F"},   32'(hif.stall_F),   32'(e_stall_F));
        check({tag, ".stall_D"},   32'(hif.stall_D),   32'(e_stall_D));
        check({tag, ".flush_D"},   32'(hif.flush_D),   32'(e_flush_D));
        check({tag, ".flush_E"},   32'(hif.flush_E),   32'(e_flush_E));
        check({tag, ".flush_M"},   32'(hif.flush_M),   32'(e_flush_M));
        check({tag, ".fwdA_E"},    32'(hif.fwdA_E),    32'(e_fwdA));
        check({tag, ".fwdB_E"},    32'(hif.fwdB_E),    32'(e_fwdB));
        check({tag, ".md_busy"},   32'(hif.md_busy),   32'(e_busy));
        check({tag, ".md_go"},     32'(hif.md_go),     32'(e_go));
        check({tag, ".stall_cnt"}, hif.stall_cnt,      e_cnt);
        check({tag, ".start_while_busy"}, 32'(hif.md_start_E && hif.md_busy), 32'd0);
    endtask

    // Advance the model across the coming rising edge, then let the DUT follow.
    task automatic tick();
        if (!rst_n) begin
            m_rem = 0;
            m_cnt = 32'd0;
        end else begin
            if (e_stall_F) m_cnt = m_cnt + 32'd1;
            if (m_rem > 0) m_rem = m_rem - 1;
            else if (hif.md_start_E && !hif.br_taken_M) m_rem = LAT;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hif.rs_D = 0; hif.rt_D = 0; hif.use_rs_D = 0; hif.use_rt_D = 0; hif.md_use_D = 0;
        hif.rs_E = 0; hif.rt_E = 0; hif.dst_E = 0;
        hif.RegWr_E = 0; hif.MemtoReg_E = 0; hif.md_start_E = 0;
        hif.dst_M = 0; hif.RegWr_M = 0; hif.MemtoReg_M = 0; hif.br_taken_M = 0;
        hif.dst_W = 0; hif.RegWr_W = 0;
    endtask

    initial begin
        // Reset with hazards and a start request all active on the inputs.
        clear_inputs();
        rst_n = 1'b0;
        hif.RegWr_M = 1; hif.dst_M = 3; hif.rs_E = 3; hif.md_start_E = 1;
        hif.RegWr_E = 1; hif.MemtoReg_E = 1; hif.dst_E = 4; hif.rs_D = 4; hif.use_rs_D = 1;
        settle("reset");
        check("reset.flush_D_hi", 32'(hif.flush_D), 32'd1);
        check("reset.md_go_lo", 32'(hif.md_go), 32'd0);
        tick();
        settle("reset2");
        tick();
        rst_n = 1'b1;
        clear_inputs();
        settle("idle");
        tick();

        // Forwarding: a load in MEM must defer to the WB copy.
        hif.RegWr_M = 1; hif.MemtoReg_M = 1; hif.dst_M = 2;
        hif.RegWr_W = 1; hif.dst_W = 2; hif.rs_E = 2; hif.rt_E = 2;
        settle("fwd_load");
        check("fwd_load.A", 32'(hif.fwdA_E), 32'd1);
        tick();
        hif.MemtoReg_M = 0;
        settle("fwd_alu");
        check("fwd_alu.A", 32'(hif.fwdA_E), 32'd2);
        tick();
        hif.dst_M = 0; hif.dst_W = 0; hif.rs_E = 0; hif.rt_E = 0;
        settle("fwd_zero");
        check("fwd_zero.B", 32'(hif.fwdB_E), 32'd0);
        tick();

        // Load-use: load in EX, then in MEM, then in WB.
        clear_inputs();
        base = m_cnt;
        hif.rs_D = 5; hif.use_rs_D = 1;
        hif.RegWr_E = 1; hif.MemtoReg_E = 1; hif.dst_E = 5;
        settle("lu0");
        check("lu0.stall", 32'({hif.stall_F, hif.stall_D, hif.flush_E, hif.flush_M}), 32'b1110);
        tick();
        hif.RegWr_E = 0; hif.MemtoReg_E = 0; hif.dst_E = 0;
        hif.RegWr_M = 1; hif.MemtoReg_M = 1; hif.dst_M = 5;
        settle("lu1");
        check("lu1.stall", 32'({hif.stall_F, hif.stall_D, hif.flush_E}), 32'b111);
        tick();
        hif.RegWr_M = 0; hif.MemtoReg_M = 0; hif.dst_M = 0;
        hif.RegWr_W = 1; hif.dst_W = 5;
        settle("lu2");
        check("lu2.release", 32'(hif.stall_F), 32'd0);
        check("lu2.count", hif.stall_cnt, base + 32'd2);
        tick();

        // Mult/div start with an mfhi waiting in ID.
        clear_inputs();
        base = m_cnt;
        hif.md_start_E = 1; hif.md_use_D = 1;
        settle("md0");
        check("md0.stall", 32'(hif.stall_F), 32'd1);
        tick();
        hif.md_start_E = 0;
        for (int c = 1; c <= LAT; c++) begin
            settle("md_busy");
            check("md_busy.hi", 32'(hif.md_busy), 32'd1);
            tick();
        end
        settle("md_done");
        check("md_done.busy", 32'(hif.md_busy), 32'd0);
        check("md_done.count", hif.stall_cnt, base + 32'(LAT + 1));
        tick();

        // Branch beats load-use and mult/div start.
        clear_inputs();
        hif.br_taken_M = 1; hif.md_start_E = 1; hif.md_use_D = 1;
        hif.RegWr_E = 1; hif.MemtoReg_E = 1; hif.dst_E = 7; hif.rt_D = 7; hif.use_rt_D = 1;
        settle("branch");
        check("branch.flushes", 32'({hif.flush_D, hif.flush_E, hif.flush_M, hif.stall_F, hif.md_go}), 32'b11100);
        tick();
        clear_inputs();
        settle("branch_after");
        check("branch_after.busy", 32'(hif.md_busy), 32'd0);
        tick();

        // Reset in the middle of a mult/div operation (counter at 10).
        hif.md_start_E = 1;
        settle("rmid0");
        tick();
        hif.md_start_E = 0;
        settle("rmid1");
        tick();
        rst_n = 1'b0;
        settle("rmid_rst");
        check("rmid_rst.out", 32'({hif.flush_D, hif.flush_E, hif.flush_M, hif.md_busy, hif.stall_F}), 32'b11100);
        tick();
        rst_n = 1'b1;
        settle("rmid_after");
        check("rmid_after.busy", 32'(hif.md_busy), 32'd0);
        check("rmid_after.count", hif.stall_cnt, 32'd0);
        tick();

        // Random pipeline traffic on a small register set to force matches.
        for (int i = 0; i < 400; i++) begin
            rst_n          = ($urandom_range(0, 49) != 0);
            hif.rs_D       = 5'($urandom_range(0, 3));
            hif.rt_D       = 5'($urandom_range(0, 3));
            hif.use_rs_D   = 1'($urandom);
            hif.use_rt_D   = 1'($urandom);
            hif.md_use_D   = ($urandom_range(0, 3) == 0);
            hif.rs_E       = 5'($urandom_range(0, 3));
            hif.rt_E       = 5'($urandom_range(0, 3));
            hif.dst_E      = 5'($urandom_range(0, 3));
            hif.RegWr_E    = 1'($urandom);
            hif.MemtoReg_E = 1'($urandom);
            hif.md_start_E = (m_rem == 0) && ($urandom_range(0, 5) == 0);
            hif.dst_M      = 5'($urandom_range(0, 3));
            hif.RegWr_M    = 1'($urandom);
            hif.MemtoReg_M = 1'($urandom);
            hif.br_taken_M = ($urandom_range(0, 7) == 0);
            hif.dst_W      = 5'($urandom_range(0, 3));
            hif.RegWr_W    = 1'($urandom);
            settle("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
